// File: rtl/d_flip_flop_rst.sv
// WIDTH-bit rising-edge D register with synchronous active-high reset and complementary output.
// Define D_FLIP_FLOP_SCAN_EN to add the scan_en/scan_in/scan_out shift path for DFT.
module d_flip_flop_rst #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  input  logic             rst
`ifdef D_FLIP_FLOP_SCAN_EN
  ,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out
`endif
);

  generate
    if (WIDTH < 1) begin : g_width_check
      $error("d_flip_flop_rst: WIDTH must be at least 1");
    end
  endgenerate

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;

`ifdef D_FLIP_FLOP_SCAN_EN
  // Scan shifts toward the MSB; bit 0 takes scan_in, every other bit its lower neighbour.
  logic [WIDTH-1:0] shift_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_lsb
        assign shift_next[gi] = scan_in;
      end else begin : g_upper
        assign shift_next[gi] = q_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    q_next = d;
    if (scan_en) begin
      q_next = shift_next;
    end
  end

  assign scan_out = q_reg[WIDTH-1];
`else
  always_comb begin
    q_next = d;
  end
`endif

  // Reset wins over both data and scan on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= RESET_VALUE;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q     = q_reg;
  assign q_bar = ~q_reg;

endmodule

// File: tb/tb_d_flip_flop_rst.sv
// Randomized scoreboard bench for d_flip_flop_rst (WIDTH=8, RESET_VALUE=8'hA5).
module tb_d_flip_flop_rst;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic [W-1:0] q_bar;
  logic         scan_en = 1'b0;
  logic         scan_in = 1'b0;
`ifdef D_FLIP_FLOP_SCAN_EN
  logic         scan_out;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_q;
  int           model_valid = 0;

  d_flip_flop_rst #(
    .WIDTH      (W),
    .RESET_VALUE(RV)
  ) dut (
    .d       (d),
    .clk     (clk),
    .q       (q),
    .q_bar   (q_bar),
    .rst     (rst)
`ifdef D_FLIP_FLOP_SCAN_EN
    ,
    .scan_en (scan_en),
    .scan_in (scan_in),
    .scan_out(scan_out)
`endif
  );

  always #5 clk = ~clk;

  // Reference: the register holds whatever the edge rules say it should, in plain arithmetic.
  task automatic issue(input logic r, input logic [W-1:0] dv, input logic se, input logic si);
    logic [W-1:0] nxt;
    rst     = r;
    d       = dv;
    scan_en = se;
    scan_in = si;
`ifdef D_FLIP_FLOP_SCAN_EN
    if (r)       nxt = RV;
    else if (se) nxt = W'((int'(model_q) * 2 + int'(si)) % 256);
    else         nxt = dv;
`else
    nxt = r ? RV : dv;
`endif
    model_q     = nxt;
    model_valid = 1;
    exp_q.push_back(nxt);
  endtask

  task automatic check_hold(input string name);
    total++;
    if (q !== model_q) begin
      bad++;
      $display("FAIL %s: q=%h required %h", name, q, model_q);
    end
  endtask

  // Monitor: the register presents a new value after every edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        total++;
        if (q !== e || q_bar !== ~e) begin
          bad++;
          $display("FAIL edge_q t=%0t: q=%h q_bar=%h required q=%h q_bar=%h", $time, q, q_bar, e, ~e);
        end else begin
          $display("t=%0t q=%h q_bar=%h ok", $time, q, q_bar);
        end
`ifdef D_FLIP_FLOP_SCAN_EN
        total++;
        if (scan_out !== e[W-1]) begin
          bad++;
          $display("FAIL scan_out t=%0t: got %b required %b", $time, scan_out, e[W-1]);
        end
`endif
      end
    end
  end

  initial begin
    int guard;
    model_q = '0;
    // Reset edge at 5 ns with d all ones.
    issue(1'b1, 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    issue(1'b0, 8'h3C, 1'b0, 1'b0);
    @(negedge clk);
    // Toggle d every 2 ns between edges; only the last value before the edge counts.
    d = 8'h11; #2 d = 8'h22; #2 check_hold("no_mid_capture");
    issue(1'b0, 8'h5E, 1'b0, 1'b0);
    @(negedge clk);
    // Reset pulse entirely between edges must not disturb q.
    rst = 1'b1; #2 rst = 1'b0; #1 check_hold("rst_between_edges");
    issue(1'b0, 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    // Reset held through the edge beats d=all ones.
    issue(1'b1, 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
`ifdef D_FLIP_FLOP_SCAN_EN
    // Reset wins over scan.
    issue(1'b1, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    issue(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    issue(1'b0, 8'hFF, 1'b1, 1'b1); @(negedge clk);
    issue(1'b0, 8'hFF, 1'b1, 1'b0); @(negedge clk);
    issue(1'b0, 8'hFF, 1'b1, 1'b1); @(negedge clk);
    issue(1'b0, 8'hFF, 1'b1, 1'b1); @(negedge clk);
`endif
    for (int i = 0; i < 200; i++) begin
      logic r, se;
      r  = ($urandom_range(0, 9) == 0);
      se = ($urandom_range(0, 3) == 0);
      if ((i % 7) == 3) begin
        d = W'($urandom); #2 d = W'($urandom); #1 check_hold("rand_mid_hold");
      end
      issue(r, W'($urandom), se, 1'($urandom));
      @(negedge clk);
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 5) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
